// File: rtl/date_counter_pkg.sv
// Shared calendar constants and the date record used by the date counter.
package date_counter_pkg;

    localparam int DAY_W  = 6;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 14;

    localparam logic [MON_W-1:0] MON_JAN = 4'd1;
    localparam logic [MON_W-1:0] MON_FEB = 4'd2;
    localparam logic [MON_W-1:0] MON_MAR = 4'd3;
    localparam logic [MON_W-1:0] MON_APR = 4'd4;
    localparam logic [MON_W-1:0] MON_MAY = 4'd5;
    localparam logic [MON_W-1:0] MON_JUN = 4'd6;
    localparam logic [MON_W-1:0] MON_JUL = 4'd7;
    localparam logic [MON_W-1:0] MON_AUG = 4'd8;
    localparam logic [MON_W-1:0] MON_SEP = 4'd9;
    localparam logic [MON_W-1:0] MON_OCT = 4'd10;
    localparam logic [MON_W-1:0] MON_NOV = 4'd11;
    localparam logic [MON_W-1:0] MON_DEC = 4'd12;

    localparam logic [DAY_W-1:0] DIM_31       = 6'd31;
    localparam logic [DAY_W-1:0] DIM_30       = 6'd30;
    localparam logic [DAY_W-1:0] DIM_FEB_LEAP = 6'd29;
    localparam logic [DAY_W-1:0] DIM_FEB      = 6'd28;

    typedef struct packed {
        logic [DAY_W-1:0]  day;
        logic [MON_W-1:0]  month;
        logic [YEAR_W-1:0] year;
    } date_t;

endpackage

// File: rtl/date_counter_days_in_month.sv
// Calendar helpers: days_in_month lookup and leap_year_calc.
// leap_year_calc uses the full Gregorian rule when GREGORIAN_LEAP_EN is defined.
module days_in_month
    import date_counter_pkg::*;
(
    input  logic [MON_W-1:0] month_i,
    input  logic             leap_i,
    output logic [DAY_W-1:0] dim_o
);

    always_comb begin
        dim_o = DIM_31;
        case (month_i)
            MON_APR, MON_JUN, MON_SEP, MON_NOV: dim_o = DIM_30;
            MON_FEB: dim_o = leap_i ? DIM_FEB_LEAP : DIM_FEB;
            default: dim_o = DIM_31;
        endcase
    end

endmodule

module leap_year_calc
    import date_counter_pkg::*;
(
    input  logic [YEAR_W-1:0] year_i,
    output logic              leap_o
);

`ifdef GREGORIAN_LEAP_EN
    logic div100;
    logic div400;
    assign div100 = ((year_i % 14'd100) == 14'd0);
    assign div400 = ((year_i % 14'd400) == 14'd0);
    assign leap_o = (year_i[1:0] == 2'b00) && (!div100 || div400);
`else
    assign leap_o = (year_i[1:0] == 2'b00);
`endif

endmodule

// File: rtl/date_counter.sv
// Day/month/year counter advanced by a midnight pulse, with validated date-set.
// Leap rule selected by GREGORIAN_LEAP_EN (Gregorian when defined, div-by-4 otherwise).
module date_counter
    import date_counter_pkg::*;
#(
    parameter logic [YEAR_W-1:0] YEAR_RESET = 14'd2000,
    parameter logic [YEAR_W-1:0] YEAR_MAX   = 14'd9999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              set_en,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [MON_W-1:0]  set_month,
    input  logic [YEAR_W-1:0] set_year,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic              month_tick,
    output logic              year_wrap,
    output logic              set_err
);

    date_t            date_q, date_d;
    logic             month_tick_q, month_tick_d;
    logic             year_wrap_q, year_wrap_d;
    logic             set_err_q, set_err_d;

    logic             set_leap;
    logic [DAY_W-1:0] cur_dim;
    logic [DAY_W-1:0] set_dim;
    logic             set_ok;
    logic             cur_mon_ok;

    leap_year_calc u_leap_cur (.year_i(date_q.year), .leap_o(leap));
    leap_year_calc u_leap_set (.year_i(set_year),    .leap_o(set_leap));

    days_in_month u_dim_cur (.month_i(date_q.month), .leap_i(leap),     .dim_o(cur_dim));
    days_in_month u_dim_set (.month_i(set_month),    .leap_i(set_leap), .dim_o(set_dim));

    assign set_ok = (set_month >= MON_JAN) && (set_month <= MON_DEC)
                 && (set_day >= 6'd1) && (set_day <= set_dim)
                 && (set_year <= YEAR_MAX);

    assign cur_mon_ok = (date_q.month >= MON_JAN) && (date_q.month <= MON_DEC);

    always_comb begin
        date_d       = date_q;
        month_tick_d = 1'b0;
        year_wrap_d  = 1'b0;
        set_err_d    = 1'b0;
        if (set_en && set_ok) begin
            date_d.day   = set_day;
            date_d.month = set_month;
            date_d.year  = set_year;
        end else begin
            set_err_d = set_en;
            // A rejected set leaves the tick in force.
            if (day_tick) begin
                if (cur_mon_ok && (date_q.day < cur_dim)) begin
                    date_d.day = date_q.day + 6'd1;
                end else begin
                    date_d.day   = 6'd1;
                    month_tick_d = 1'b1;
                    if (!cur_mon_ok) begin
                        date_d.month = MON_JAN;
                    end else if (date_q.month == MON_DEC) begin
                        date_d.month = MON_JAN;
                        if (date_q.year >= YEAR_MAX) begin
                            date_d.year = '0;
                            year_wrap_d = 1'b1;
                        end else begin
                            date_d.year = date_q.year + 14'd1;
                        end
                    end else begin
                        date_d.month = date_q.month + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            date_q.day   <= 6'd1;
            date_q.month <= MON_JAN;
            date_q.year  <= YEAR_RESET;
            month_tick_q <= 1'b0;
            year_wrap_q  <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            date_q       <= date_d;
            month_tick_q <= month_tick_d;
            year_wrap_q  <= year_wrap_d;
            set_err_q    <= set_err_d;
        end
    end

    assign day        = date_q.day;
    assign month      = date_q.month;
    assign year       = date_q.year;
    assign month_tick = month_tick_q;
    assign year_wrap  = year_wrap_q;
    assign set_err    = set_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter; expected dates are hand-computed calendar values.
module tb_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        day_tick = 1'b0;
    logic        set_en = 1'b0;
    logic [5:0]  set_day = '0;
    logic [3:0]  set_month = '0;
    logic [13:0] set_year = '0;
    logic [5:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic        leap;
    logic        month_tick;
    logic        year_wrap;
    logic        set_err;

    int n_checks = 0;
    int n_errs   = 0;

    date_counter #(.YEAR_RESET(14'd2000), .YEAR_MAX(14'd9999)) dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .set_en(set_en),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .day(day), .month(month), .year(year), .leap(leap),
        .month_tick(month_tick), .year_wrap(year_wrap), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_date(input string tag, input int d, input int m, input int y);
        check({tag, ".day"},   int'(day),   d);
        check({tag, ".month"}, int'(month), m);
        check({tag, ".year"},  int'(year),  y);
    endtask

    task automatic check_pulses(input string tag, input int mt, input int yw, input int se);
        check({tag, ".month_tick"}, int'(month_tick), mt);
        check({tag, ".year_wrap"},  int'(year_wrap),  yw);
        check({tag, ".set_err"},    int'(set_err),    se);
    endtask

    // One clock: inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic cycle(input logic tk, input logic se, input int d, input int m, input int y);
        @(negedge clk);
        day_tick  = tk;
        set_en    = se;
        set_day   = 6'(d);
        set_month = 4'(m);
        set_year  = 14'(y);
        @(posedge clk);
        #1;
        day_tick = 1'b0;
        set_en   = 1'b0;
        $display("txn tick=%0b set=%0b(%0d/%0d/%0d) -> %0d/%0d/%0d mt=%0b yw=%0b err=%0b",
                 tk, se, d, m, y, day, month, year, month_tick, year_wrap, set_err);
    endtask

    task automatic tick();
        cycle(1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic set_date(input int d, input int m, input int y);
        cycle(1'b0, 1'b1, d, m, y);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_date("reset", 1, 1, 2000);
        check_pulses("reset", 0, 0, 0);
        check("reset.leap", int'(leap), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // January 2000: 30 ticks walk to the 31st, the next one rolls into February.
        for (int i = 2; i <= 31; i++) begin
            tick();
            check("jan.day", int'(day), i);
            check("jan.month_tick", int'(month_tick), 0);
        end
        tick();
        check_date("jan_roll", 1, 2, 2000);
        check_pulses("jan_roll", 1, 0, 0);
        idle();
        check_pulses("jan_roll_after", 0, 0, 0);

        set_date(28, 2, 2024);
        check_date("set_2024", 28, 2, 2024);
        check_pulses("set_2024", 0, 0, 0);
        tick();
        check_date("feb29_2024", 29, 2, 2024);
        check("leap_2024", int'(leap), 1);
        tick();
        check_date("mar1_2024", 1, 3, 2024);
        check_pulses("mar1_2024", 1, 0, 0);

        set_date(28, 2, 2023);
        check("leap_2023", int'(leap), 0);
        tick();
        check_date("mar1_2023", 1, 3, 2023);
        check_pulses("mar1_2023", 1, 0, 0);
        set_date(29, 2, 2023);
        check_date("bad_feb29", 1, 3, 2023);
        check_pulses("bad_feb29", 0, 0, 1);
        idle();
        check("bad_feb29_after.set_err", int'(set_err), 0);

        set_date(31, 12, 9999);
        check_date("set_9999", 31, 12, 9999);
        tick();
        check_date("wrap", 1, 1, 0);
        check_pulses("wrap", 1, 1, 0);
        idle();
        check_pulses("wrap_after", 0, 0, 0);

        set_date(28, 2, 1900);
        tick();
`ifdef GREGORIAN_LEAP_EN
        check_date("y1900", 1, 3, 1900);
        check("y1900.month_tick", int'(month_tick), 1);
`else
        check_date("y1900", 29, 2, 1900);
        check("y1900.month_tick", int'(month_tick), 0);
`endif
        set_date(28, 2, 2000);
        tick();
        check_date("y2000", 29, 2, 2000);

        // Validation boundaries: day 0, month 13, year past max, 30 April ok, 31 April not.
        set_date(0, 5, 2030);
        check_pulses("day0", 0, 0, 1);
        check_date("day0", 29, 2, 2000);
        set_date(1, 13, 2030);
        check("mon13.set_err", int'(set_err), 1);
        set_date(1, 0, 2030);
        check("mon0.set_err", int'(set_err), 1);
        set_date(1, 1, 10000);
        check("y10000.set_err", int'(set_err), 1);
        set_date(29, 2, 2024);
        check_date("set_feb29_2024", 29, 2, 2024);
        check("set_feb29_2024.set_err", int'(set_err), 0);
        set_date(30, 4, 2030);
        tick();
        check_date("apr30_roll", 1, 5, 2030);

        cycle(1'b1, 1'b1, 15, 6, 2030);
        check_date("set_and_tick", 15, 6, 2030);
        check_pulses("set_and_tick", 0, 0, 0);
        cycle(1'b1, 1'b1, 31, 4, 2030);
        check_date("badset_and_tick", 16, 6, 2030);
        check_pulses("badset_and_tick", 0, 0, 1);

        tick();
        tick();
        check_date("pre_reset", 18, 6, 2030);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_date("async_reset", 1, 1, 2000);
        check_pulses("async_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_date("post_reset_tick", 2, 1, 2000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
